// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad-configuration chain loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_cfg_pkg;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LOAD     = 3'd4,
        DONE     = 3'd5
    } gpio_cfg_state_e;

    // Width of one gpio_control_block shift register.
    localparam int GPIO_PAD_CTRL_BITS = 12;

    // Power-on contents of a pad-control register.
    localparam logic [11:0] GPIO_CTRL_DEFAULTS = 12'hC00;

    // Counter width helper: max(1, $clog2(n)).
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_cfg_loader_if.sv
// Management-side bundle for the pad-configuration loader: start/busy/done
// handshake, per-pad word fetch (cfg_idx -> cfg_data, same cycle) and the
// three serial-chain drive lines.
// Backpressure: none; cfg_data must be valid combinationally for cfg_idx.
// Ports (master = loader side):
//   cfg_start in, cfg_data in, cfg_busy/cfg_done/cfg_idx out,
//   serial_clock_out/serial_data_out/serial_load_out out.
interface gpio_cfg_loader_if #(
    parameter int IDX_W         = 4,
    parameter int PAD_CTRL_BITS = 12
);
    logic                     cfg_start;
    logic                     cfg_busy;
    logic                     cfg_done;
    logic [IDX_W-1:0]         cfg_idx;
    logic [PAD_CTRL_BITS-1:0] cfg_data;
    logic                     serial_clock_out;
    logic                     serial_data_out;
    logic                     serial_load_out;

    modport master (
        input  cfg_start,
        input  cfg_data,
        output cfg_busy,
        output cfg_done,
        output cfg_idx,
        output serial_clock_out,
        output serial_data_out,
        output serial_load_out
    );

    modport slave (
        output cfg_start,
        output cfg_data,
        input  cfg_busy,
        input  cfg_done,
        input  cfg_idx,
        input  serial_clock_out,
        input  serial_data_out,
        input  serial_load_out
    );
endinterface

// File: rtl/gpio_cfg_clkgen.sv
// Half-period timer for the serial chain clock: phase_end_o marks the last
// mclk cycle of each CLK_DIV-cycle window.
// Backpressure: none; counts only while run_i is high.
// Ports: mclk, resetn (async active-low), run_i (count enable), phase_end_o.
module gpio_cfg_clkgen
    import gpio_cfg_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic mclk,
    input  logic resetn,
    input  logic run_i,
    output logic phase_end_o
);

    localparam int            CW   = clog2_min1(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter sits at zero outside the timed states and wraps on every
    // phase_end; every transition into SHIFT_LO/SHIFT_HI/LOAD happens either
    // from an untimed state or on a phase_end, so each timed state always
    // starts a fresh window.
    always_comb begin
        phase_end_o = run_i && (cnt_q == LAST);
        cnt_d       = cnt_q;
        if (!run_i || phase_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_cfg_loader.sv
// Serial-chain master: on cfg_start fetches one word per pad (farthest pad
// first), shifts each MSB first under a divided clock, then strobes load.
// Latency: busy NUM_PADS*(1+2*CLK_DIV*PAD_CTRL_BITS)+2*CLK_DIV cycles, done next.
// Backpressure: none; cfg_start outside IDLE is dropped, not queued.
// Ports: mclk, resetn (async active-low), bus (gpio_cfg_loader_if.master).
module gpio_cfg_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS      = 15,
    parameter int PAD_CTRL_BITS = GPIO_PAD_CTRL_BITS,
    parameter int CLK_DIV       = 2
) (
    input  logic              mclk,
    input  logic              resetn,
    gpio_cfg_loader_if.master bus
);

    localparam int               IDX_W    = clog2_min1(NUM_PADS);
    localparam int               BIT_W    = clog2_min1(PAD_CTRL_BITS);
    localparam logic [IDX_W-1:0] LAST_PAD = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAD_CTRL_BITS - 1);

    gpio_cfg_state_e          state_q;
    logic [IDX_W-1:0]         pad_cnt_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [PAD_CTRL_BITS-1:0] sreg_q;
    logic [PAD_CTRL_BITS-1:0] sreg_d;
    logic                     load_half_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     sclk_q;
    logic                     sdat_q;
    logic                     load_q;
    logic                     run;
    logic                     phase_end;

    assign run    = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LOAD);
    assign sreg_d = sreg_q << 1;

    gpio_cfg_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .mclk        (mclk),
        .resetn      (resetn),
        .run_i       (run),
        .phase_end_o (phase_end)
    );

    // Every output is a flop updated together with the state it belongs to,
    // so the chain lines change only on mclk edges and an async reset clears
    // them at once (a half-finished load strobe is cut off with everything else).
    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pad_cnt_q   <= LAST_PAD;
            bit_cnt_q   <= '0;
            sreg_q      <= PAD_CTRL_BITS'(GPIO_CTRL_DEFAULTS);
            load_half_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sclk_q      <= 1'b0;
            sdat_q      <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cfg_start) begin
                        pad_cnt_q <= LAST_PAD;
                        busy_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    // cfg_idx is the pad counter; the source answers in this cycle.
                    sreg_q    <= bus.cfg_data;
                    bit_cnt_q <= LAST_BIT;
                    sdat_q    <= bus.cfg_data[PAD_CTRL_BITS-1];
                    state_q   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        sclk_q <= 1'b0;
                        sreg_q <= sreg_d;
                        if (bit_cnt_q != '0) begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                            sdat_q    <= sreg_d[PAD_CTRL_BITS-1];
                            state_q   <= SHIFT_LO;
                        end else if (pad_cnt_q != '0) begin
                            pad_cnt_q <= pad_cnt_q - 1'b1;
                            state_q   <= FETCH;
                        end else begin
                            sdat_q      <= 1'b0;
                            load_q      <= 1'b1;
                            load_half_q <= 1'b0;
                            state_q     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // The strobe spans two timer windows.
                    if (phase_end) begin
                        if (load_half_q) begin
                            load_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            load_half_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_busy         = busy_q;
    assign bus.cfg_done         = done_q;
    assign bus.cfg_idx          = pad_cnt_q;
    assign bus.serial_clock_out = sclk_q;
    assign bus.serial_data_out  = sdat_q;
    assign bus.serial_load_out  = load_q;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: three instances (defaults, 1 pad / CLK_DIV 1,
// 3 pads / CLK_DIV 3) observed through one selectable monitor that models
// the downstream chain of shift registers and their load latches.
`timescale 1ns/1ps
module tb_gpio_cfg_loader;

    logic mclk   = 1'b0;
    logic resetn = 1'b0;
    always #5 mclk = ~mclk;

    gpio_cfg_loader_if #(.IDX_W(4), .PAD_CTRL_BITS(12)) a_if ();
    gpio_cfg_loader_if #(.IDX_W(1), .PAD_CTRL_BITS(12)) b_if ();
    gpio_cfg_loader_if #(.IDX_W(2), .PAD_CTRL_BITS(12)) c_if ();

    gpio_cfg_loader #(.NUM_PADS(15), .PAD_CTRL_BITS(12), .CLK_DIV(2)) dut_a (
        .mclk(mclk), .resetn(resetn), .bus(a_if));
    gpio_cfg_loader #(.NUM_PADS(1), .PAD_CTRL_BITS(12), .CLK_DIV(1)) dut_b (
        .mclk(mclk), .resetn(resetn), .bus(b_if));
    gpio_cfg_loader #(.NUM_PADS(3), .PAD_CTRL_BITS(12), .CLK_DIV(3)) dut_c (
        .mclk(mclk), .resetn(resetn), .bus(c_if));

    logic [11:0] words_a [15];
    logic [11:0] word_b;
    logic [11:0] words_c [3];

    always_comb a_if.cfg_data = words_a[a_if.cfg_idx];
    always_comb b_if.cfg_data = word_b;
    always_comb c_if.cfg_data = words_c[c_if.cfg_idx];

    int tests = 0;
    int fails = 0;
    int sel   = 0;
    logic mon_clr = 1'b0;

    logic m_sclk, m_sdat, m_load, m_busy, m_done;
    always_comb begin
        case (sel)
            0:       {m_sclk, m_sdat, m_load, m_busy, m_done} = {a_if.serial_clock_out,
                      a_if.serial_data_out, a_if.serial_load_out, a_if.cfg_busy, a_if.cfg_done};
            1:       {m_sclk, m_sdat, m_load, m_busy, m_done} = {b_if.serial_clock_out,
                      b_if.serial_data_out, b_if.serial_load_out, b_if.cfg_busy, b_if.cfg_done};
            default: {m_sclk, m_sdat, m_load, m_busy, m_done} = {c_if.serial_clock_out,
                      c_if.serial_data_out, c_if.serial_load_out, c_if.cfg_busy, c_if.cfg_done};
        endcase
    end

    // Monitor / reference chain: pad 0 is nearest the loader, so each rising
    // serial clock pushes data into pad 0 and every pad's MSB into the next.
    int   cyc = 0, rises = 0, loads = 0, dones = 0, glitches = 0, overlaps = 0;
    int   busy_first = -1, busy_last = -1, np = 15;
    int   done_cycs[$];
    int   fetch_cycs[$];
    logic bits_q[$];
    logic [11:0] chain   [15];
    logic [11:0] latched [15];
    logic prev_sclk = 1'b0, prev_load = 1'b0, prev_busy = 1'b0, held = 1'b0;

    always @(negedge mclk) begin
        np = (sel == 0) ? 15 : (sel == 1) ? 1 : 3;
        if (mon_clr) begin
            cyc = 0; rises = 0; loads = 0; dones = 0; glitches = 0; overlaps = 0;
            busy_first = -1; busy_last = -1;
            done_cycs.delete(); fetch_cycs.delete(); bits_q.delete();
            for (int k = 0; k < 15; k++) begin
                chain[k]   = 12'h000;
                latched[k] = 'x;
            end
        end else begin
            cyc++;
            if (m_sclk === 1'b1 && prev_sclk !== 1'b1) begin
                rises++;
                bits_q.push_back(m_sdat);
                held = m_sdat;
                for (int k = 14; k >= 1; k--)
                    if (k < np) chain[k] = {chain[k][10:0], chain[k-1][11]};
                chain[0] = {chain[0][10:0], m_sdat};
            end else if (m_sclk === 1'b1 && m_sdat !== held) begin
                glitches++;
            end
            if (m_load === 1'b1 && prev_load !== 1'b1) begin
                loads++;
                for (int k = 0; k < 15; k++) latched[k] = chain[k];
            end
            if (m_load === 1'b1 && m_sclk === 1'b1) overlaps++;
            if (m_busy === 1'b1) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
                if (prev_busy !== 1'b1) fetch_cycs.push_back(cyc);
            end
            if (m_done === 1'b1) begin
                dones++;
                done_cycs.push_back(cyc);
            end
        end
        prev_sclk = m_sclk;
        prev_load = m_load;
        prev_busy = m_busy;
    end

    // Cycle in which cfg_done is expected, counting the start cycle as 0.
    function automatic int exp_done(input int pads, input int cd);
        return pads * (1 + 2 * cd * 12) + 2 * cd + 1;
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic set_start(input logic v);
        a_if.cfg_start = (sel == 0) ? v : 1'b0;
        b_if.cfg_start = (sel == 1) ? v : 1'b0;
        c_if.cfg_start = (sel == 2) ? v : 1'b0;
    endtask

    task automatic pulse_start();
        set_start(1'b1);
        mon_clr = 1'b1;
        tick();
        set_start(1'b0);
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && dones == 0; i++) tick();
        tests++;
        if (dones < 1) begin
            fails++;
            $display("FAIL done_timeout: no cfg_done within %0d cycles", budget);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        tests++; if (a_if.cfg_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", a_if.cfg_busy); end
        tests++; if (a_if.cfg_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", a_if.cfg_done); end
        tests++; if (a_if.serial_clock_out !== 1'b0) begin fails++; $display("FAIL rst_sclk: got %b want 0", a_if.serial_clock_out); end
        tests++; if (a_if.serial_data_out !== 1'b0) begin fails++; $display("FAIL rst_sdat: got %b want 0", a_if.serial_data_out); end
        tests++; if (a_if.serial_load_out !== 1'b0) begin fails++; $display("FAIL rst_load: got %b want 0", a_if.serial_load_out); end
        tests++; if (a_if.cfg_idx !== 4'd14) begin fails++; $display("FAIL rst_idx_a: got %0d want 14", a_if.cfg_idx); end
        tests++; if (b_if.cfg_idx !== 1'd0) begin fails++; $display("FAIL rst_idx_b: got %0d want 0", b_if.cfg_idx); end
        tests++; if (c_if.cfg_idx !== 2'd2) begin fails++; $display("FAIL rst_idx_c: got %0d want 2", c_if.cfg_idx); end
    endtask

    task automatic check_seq(input string tag, input int pads, input int cd, input int want_done);
        tests++; if (done_cycs.size() < 1 || done_cycs[0] != want_done) begin fails++;
            $display("FAIL %s_done_cycle: got %0d want %0d", tag, (done_cycs.size() > 0) ? done_cycs[0] : -1, want_done); end
        tests++; if (busy_first != 1 || busy_last != want_done - 1) begin fails++;
            $display("FAIL %s_busy_window: got %0d..%0d want 1..%0d", tag, busy_first, busy_last, want_done - 1); end
        tests++; if (rises != pads * 12) begin fails++; $display("FAIL %s_rises: got %0d want %0d", tag, rises, pads * 12); end
        tests++; if (loads != 1 || dones != 1) begin fails++; $display("FAIL %s_pulses: load %0d done %0d want 1 1", tag, loads, dones); end
        tests++; if (glitches != 0 || overlaps != 0) begin fails++;
            $display("FAIL %s_protocol: glitches %0d overlaps %0d want 0 0", tag, glitches, overlaps); end
        for (int k = 0; k < pads; k++) begin
            logic [11:0] want;
            want = (sel == 0) ? words_a[k] : (sel == 1) ? word_b : words_c[k];
            tests++;
            if (latched[k] !== want) begin fails++; $display("FAIL %s_pad%0d: got %h want %h", tag, k, latched[k], want); end
        end
    endtask

    task automatic test_distinct_words();
        sel = 0;
        for (int k = 0; k < 15; k++) words_a[k] = 12'hA00 + 12'(k);
        pulse_start();
        wait_done(1000);
        check_seq("distinct", 15, 2, 740);
    endtask

    task automatic test_min_config();
        logic [11:0] exp_bits;
        sel = 1;
        word_b   = 12'h5A3;
        exp_bits = 12'b0101_1010_0011;
        pulse_start();
        wait_done(100);
        check_seq("min", 1, 1, exp_done(1, 1));
        tests++; if (bits_q.size() != 12) begin fails++; $display("FAIL min_bitcount: got %0d want 12", bits_q.size()); end
        for (int i = 0; i < 12 && i < bits_q.size(); i++) begin
            tests++;
            if (bits_q[i] !== exp_bits[11-i]) begin fails++; $display("FAIL min_bit%0d: got %b want %b", i, bits_q[i], exp_bits[11-i]); end
        end
    endtask

    task automatic test_start_while_busy();
        sel = 0;
        for (int k = 0; k < 15; k++) words_a[k] = 12'($urandom_range(0, 4095));
        pulse_start();
        for (int n = 1; n < 800; n++) begin
            set_start((n == 1 || n == 300 || n == 739) ? 1'b1 : 1'b0);
            tick();
        end
        set_start(1'b0);
        repeat (4) tick();
        check_seq("busy_start", 15, 2, 740);
    endtask

    task automatic test_back_to_back();
        int period, want_seqs;
        sel = 1;
        word_b = 12'($urandom_range(0, 4095));
        period    = exp_done(1, 1) + 1;   // DONE, then IDLE accepts the next start
        want_seqs = 99 / period + 1;      // start held high for cycles 0..99
        set_start(1'b1);
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        repeat (99) tick();
        set_start(1'b0);
        repeat (60) tick();
        tests++; if (dones != want_seqs || fetch_cycs.size() != want_seqs) begin fails++;
            $display("FAIL b2b_count: done %0d fetch %0d want %0d", dones, fetch_cycs.size(), want_seqs); end
        tests++; if (fetch_cycs.size() < 1 || fetch_cycs[0] != 1) begin fails++;
            $display("FAIL b2b_first_fetch: got %0d want 1", (fetch_cycs.size() > 0) ? fetch_cycs[0] : -1); end
        for (int i = 0; i + 1 < fetch_cycs.size() && i < done_cycs.size(); i++) begin
            tests++;
            if (fetch_cycs[i+1] - done_cycs[i] != 2) begin fails++;
                $display("FAIL b2b_gap%0d: got %0d want 2", i, fetch_cycs[i+1] - done_cycs[i]); end
            tests++;
            if (done_cycs[i] - fetch_cycs[i] != exp_done(1, 1) - 1) begin fails++;
                $display("FAIL b2b_len%0d: got %0d want %0d", i, done_cycs[i] - fetch_cycs[i], exp_done(1, 1) - 1); end
        end
        tests++; if (latched[0] !== word_b) begin fails++; $display("FAIL b2b_pad0: got %h want %h", latched[0], word_b); end
    endtask

    task automatic test_reset_mid_shift();
        sel = 0;
        for (int k = 0; k < 15; k++) words_a[k] = 12'($urandom_range(0, 4095));
        pulse_start();
        repeat (399) tick();
        #2 resetn = 1'b0;
        #1;
        tests++; if ({a_if.cfg_busy, a_if.cfg_done, a_if.serial_clock_out, a_if.serial_data_out, a_if.serial_load_out} !== 5'b0) begin
            fails++; $display("FAIL midrst_outputs: got %b want 00000", {a_if.cfg_busy, a_if.cfg_done,
                     a_if.serial_clock_out, a_if.serial_data_out, a_if.serial_load_out}); end
        tests++; if (a_if.cfg_idx !== 4'd14) begin fails++; $display("FAIL midrst_idx: got %0d want 14", a_if.cfg_idx); end
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        tests++; if (loads != 0 || dones != 0) begin fails++;
            $display("FAIL midrst_no_load: load %0d done %0d want 0 0", loads, dones); end
        for (int k = 0; k < 15; k++) words_a[k] = 12'($urandom_range(0, 4095));
        pulse_start();
        wait_done(1000);
        check_seq("after_rst", 15, 2, 740);
    endtask

    task automatic test_glitch_free();
        sel = 2;
        for (int k = 0; k < 3; k++) words_c[k] = 12'($urandom_range(0, 4095));
        pulse_start();
        wait_done(400);
        check_seq("div3", 3, 3, exp_done(3, 3));
    endtask

    initial begin
        for (int k = 0; k < 15; k++) words_a[k] = 12'h000;
        for (int k = 0; k < 3; k++) words_c[k] = 12'h000;
        word_b = 12'h000;
        set_start(1'b0);
        repeat (3) tick();
        test_reset();
        resetn = 1'b1;
        repeat (2) tick();
        test_distinct_words();
        test_min_config();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_shift();
        test_glitch_free();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
